// File: rtl/mask_match_scheduler.sv
// mask_match_scheduler
//   Accepts one (weight, activation) nonzero-mask pair per block and walks
//   every position where both masks are set, lowest position first. Each
//   beat reports where that element sits in the compressed W and A streams
//   (the count of ones below that position in each mask). A block with no
//   mutual match produces a single empty beat, so the block still closes.
//
// Ports
//   clock            sole clock, rising edge
//   reset            asynchronous, active-high
//   ivalid / oready  upstream handshake (oready high only while idle)
//   bitmaskW/A       nonzero masks, LSB = position 0
//   ovalid / iready  downstream handshake
//   weightIndex      compressed-W offset of the current match
//   activationIndex  compressed-A offset of the current match
//   isLast           final beat of the block
//   isEmpty          block had no mutual match; beat carries no operands
//   numDenseW/A      popcounts of the latched masks, constant over a block
module mask_match_scheduler #(
  parameter int BITMASK_LENGTH = 16,
  parameter int INDEX_BITWIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ivalid,
  output logic                      oready,
  input  logic [BITMASK_LENGTH-1:0] bitmaskW,
  input  logic [BITMASK_LENGTH-1:0] bitmaskA,
  output logic                      ovalid,
  input  logic                      iready,
  output logic [INDEX_BITWIDTH-1:0] weightIndex,
  output logic [INDEX_BITWIDTH-1:0] activationIndex,
  output logic                      isLast,
  output logic                      isEmpty,
  output logic [INDEX_BITWIDTH-1:0] numDenseW,
  output logic [INDEX_BITWIDTH-1:0] numDenseA
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [BITMASK_LENGTH-1:0] MASK_ONE  = {{(BITMASK_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [BITMASK_LENGTH-1:0] MASK_ZERO = {BITMASK_LENGTH{1'b0}};
  localparam logic [INDEX_BITWIDTH-1:0] IDX_ZERO  = {INDEX_BITWIDTH{1'b0}};

  // Number of set bits in a mask.
  function automatic logic [INDEX_BITWIDTH-1:0] popcount(input logic [BITMASK_LENGTH-1:0] v);
    logic [INDEX_BITWIDTH-1:0] c;
    c = IDX_ZERO;
    for (int i = 0; i < BITMASK_LENGTH; i++) begin
      c = c + {{(INDEX_BITWIDTH-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  state_t                      state_r, state_n;
  logic [BITMASK_LENGTH-1:0]   mask_w_r, mask_w_n;
  logic [BITMASK_LENGTH-1:0]   mask_a_r, mask_a_n;
  logic [BITMASK_LENGTH-1:0]   remain_r, remain_n;
  logic [INDEX_BITWIDTH-1:0]   num_w_r, num_w_n;
  logic [INDEX_BITWIDTH-1:0]   num_a_r, num_a_n;

  logic [BITMASK_LENGTH-1:0]   low_bit_s;
  logic [BITMASK_LENGTH-1:0]   below_s;
  logic                        issue_s;
  logic                        empty_s;
  logic                        last_s;
  logic                        accept_s;
  logic                        fire_s;

  // Beat decode: everything here depends only on registered state, so the
  // beat holds naturally while the consumer stalls.
  always_comb begin
    issue_s   = (state_r == ISSUE);
    // Two's-complement trick isolates the lowest set bit of remaining.
    low_bit_s = remain_r & (~remain_r + MASK_ONE);
    // Positions strictly below p; meaningless when remaining is zero, in
    // which case the indices are forced to zero below.
    below_s   = low_bit_s - MASK_ONE;
    empty_s   = (remain_r == MASK_ZERO);
    // Zero or exactly one set bit left means this is the closing beat.
    last_s    = ((remain_r & (remain_r - MASK_ONE)) == MASK_ZERO);
  end

  // Handshake and output drive; oready drops combinationally under reset.
  always_comb begin
    oready          = (state_r == IDLE) && !reset;
    ovalid          = issue_s;
    accept_s        = ivalid && oready;
    fire_s          = issue_s && iready;
    isLast          = issue_s && last_s;
    isEmpty         = issue_s && empty_s;
    numDenseW       = num_w_r;
    numDenseA       = num_a_r;
    weightIndex     = IDX_ZERO;
    activationIndex = IDX_ZERO;
    if (issue_s && !empty_s) begin
      weightIndex     = popcount(mask_w_r & below_s);
      activationIndex = popcount(mask_a_r & below_s);
    end else begin
      weightIndex     = IDX_ZERO;
      activationIndex = IDX_ZERO;
    end
  end

  // Next-state logic: latch a block on accept, retire one match per fire.
  always_comb begin
    state_n  = state_r;
    mask_w_n = mask_w_r;
    mask_a_n = mask_a_r;
    remain_n = remain_r;
    num_w_n  = num_w_r;
    num_a_n  = num_a_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          mask_w_n = bitmaskW;
          mask_a_n = bitmaskA;
          remain_n = bitmaskW & bitmaskA;
          num_w_n  = popcount(bitmaskW);
          num_a_n  = popcount(bitmaskA);
          state_n  = ISSUE;
        end else begin
          state_n  = IDLE;
        end
      end
      ISSUE: begin
        if (fire_s) begin
          remain_n = remain_r & ~low_bit_s;
          if (last_s) begin
            state_n = IDLE;
          end else begin
            state_n = ISSUE;
          end
        end else begin
          state_n = ISSUE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register; reset discards any block in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      mask_w_r <= MASK_ZERO;
      mask_a_r <= MASK_ZERO;
      remain_r <= MASK_ZERO;
      num_w_r  <= IDX_ZERO;
      num_a_r  <= IDX_ZERO;
    end else begin
      state_r  <= state_n;
      mask_w_r <= mask_w_n;
      mask_a_r <= mask_a_n;
      remain_r <= remain_n;
      num_w_r  <= num_w_n;
      num_a_r  <= num_a_n;
    end
  end

endmodule
